// File: rtl/sync_pipe_arb.sv
// Arbitrated front end for a shared DP-stage delay pipeline with valid/ready output stall.
// Define SYNC_PIPE_ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module sync_pipe_arb #(
  parameter int unsigned NR = 4,
  parameter int unsigned DP = 2,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    req,
  input  logic [NR*DW-1:0] din,
  output logic [NR-1:0]    gnt,
  input  logic             flush,
  input  logic             dout_rdy,
  output logic             dout_vld,
  output logic [IW-1:0]    dout_id,
  output logic [DW-1:0]    dout,
  output logic             busy
);

  logic [DP-1:0] vld_q;
  logic [IW-1:0] id_q   [DP];
  logic [DW-1:0] data_q [DP];

  logic          adv;
  logic          accept;
  logic          win_vld;
  logic [IW-1:0] win_id;
  logic [DW-1:0] win_data;

  assign dout_vld = vld_q[DP-1];
  assign dout_id  = id_q[DP-1];
  assign dout     = data_q[DP-1];
  assign busy     = |vld_q;

  // The whole pipeline moves only when the output stage can be vacated.
  assign adv    = !vld_q[DP-1] || dout_rdy;
  assign accept = !rst && !flush && adv && win_vld;

`ifdef SYNC_PIPE_ARB_RR_EN
  logic [IW-1:0] ptr_q;

  always_comb begin
    int unsigned idx;
    idx      = 0;
    win_vld  = 1'b0;
    win_id   = '0;
    win_data = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(ptr_q) + k) % NR;
      if (!win_vld && req[idx]) begin
        win_vld  = 1'b1;
        win_id   = IW'(idx);
        win_data = din[idx*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (32'(win_id) == NR - 1) ? '0 : win_id + 1'b1;
    end
  end
`else
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_data = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!win_vld && req[k]) begin
        win_vld  = 1'b1;
        win_id   = IW'(k);
        win_data = din[k*DW +: DW];
      end
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (accept) begin
      gnt[win_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= '0;
      for (int k = 0; k < DP; k++) begin
        id_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else if (adv) begin
      // Bubbles carry zeroed id/data so an idle output reads as all zeros.
      vld_q[0]  <= accept;
      id_q[0]   <= accept ? win_id : '0;
      data_q[0] <= accept ? win_data : '0;
      for (int k = 1; k < DP; k++) begin
        vld_q[k]  <= vld_q[k-1];
        id_q[k]   <= id_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_sync_pipe_arb.sv
// Randomized bench for sync_pipe_arb with a queue-based reference model.
// Honours SYNC_PIPE_ARB_RR_EN the same way as the design.
module tb_sync_pipe_arb;
  localparam int unsigned NR = 4;
  localparam int unsigned DP = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] din;
  logic [NR-1:0]    gnt;
  logic             flush;
  logic             dout_rdy;
  logic             dout_vld;
  logic [IW-1:0]    dout_id;
  logic [DW-1:0]    dout;
  logic             busy;

  sync_pipe_arb #(.NR(NR), .DP(DP), .DW(DW), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .flush    (flush),
    .dout_rdy (dout_rdy),
    .dout_vld (dout_vld),
    .dout_id  (dout_id),
    .dout     (dout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    int            pos;
  } item_t;

  item_t         q[$];
  logic [NR-1:0] last_gnt;
  int            checks;
  int            failures;
  int            id3_seen;
`ifdef SYNC_PIPE_ARB_RR_EN
  int            mptr;
`endif

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Check combinational outputs against the model, then advance one clock.
  task automatic tick();
    logic          exp_vld;
    logic          adv;
    logic [NR-1:0] eg;
    logic [IW-1:0] eid;
    logic [DW-1:0] edat;
    int            win;
    int            idx;
    item_t         it;
    @(negedge clk);
    exp_vld = (q.size() > 0) && (q[0].pos == DP - 1);
    eid     = exp_vld ? q[0].id : '0;
    edat    = exp_vld ? q[0].data : '0;
    adv     = !exp_vld || dout_rdy;
    win     = -1;
    for (int k = 0; k < NR; k++) begin
`ifdef SYNC_PIPE_ARB_RR_EN
      idx = (mptr + k) % NR;
`else
      idx = k;
`endif
      if (win < 0 && req[idx]) win = idx;
    end
    eg = '0;
    if (!rst && !flush && adv && win >= 0) eg[win] = 1'b1;

    check_eq("gnt", 64'(gnt), 64'(eg));
    check_eq("dout_vld", 64'(dout_vld), 64'(exp_vld));
    check_eq("dout_id", 64'(dout_id), 64'(eid));
    check_eq("dout", 64'(dout), 64'(edat));
    check_eq("busy", 64'(busy), 64'(q.size() > 0));
    if (dout_vld && dout_id == 2'd3) id3_seen++;
    last_gnt = eg;

    if (rst) begin
      q.delete();
`ifdef SYNC_PIPE_ARB_RR_EN
      mptr = 0;
`endif
    end else if (flush) begin
      q.delete();
    end else if (adv) begin
      if (exp_vld) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) q[i].pos = q[i].pos + 1;
      if (win >= 0) begin
        it.id   = IW'(win);
        it.data = din[win*DW +: DW];
        it.pos  = 0;
        q.push_back(it);
`ifdef SYNC_PIPE_ARB_RR_EN
        mptr = (win + 1) % NR;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Granted requesters get fresh data so every accepted word is distinct.
  task automatic regen();
    for (int i = 0; i < NR; i++) begin
      if (last_gnt[i]) din[i*DW +: DW] = $urandom;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    id3_seen = 0;
    last_gnt = '0;
`ifdef SYNC_PIPE_ARB_RR_EN
    mptr = 0;
`endif
    rst      = 1'b1;
    flush    = 1'b0;
    dout_rdy = 1'b1;
    req      = 4'b1111;
    din      = '0;
    for (int i = 0; i < NR; i++) din[i*DW +: DW] = $urandom;
    @(posedge clk);
    #1;

    // Reset held with all requesters asserted, then contention.
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      regen();
    end
    req = '0;
    repeat (DP + 2) tick();

    // Single request latency.
    req = 4'b0100;
    din[2*DW +: DW] = 32'hA5A5_0001;
    tick();
    req = '0;
    repeat (DP + 1) tick();

    // Backpressure mid-stream.
    req = 4'b0001;
    repeat (2) begin
      tick();
      regen();
    end
    req = 4'b1111;
    dout_rdy = 1'b0;
    repeat (3) tick();
    dout_rdy = 1'b1;
    req = 4'b0001;
    repeat (2) begin
      tick();
      regen();
    end
    req = '0;
    repeat (DP + 2) tick();

    // Flush with two words in flight, requester 1 waiting.
    req = 4'b0001;
    repeat (2) begin
      tick();
      regen();
    end
    req = 4'b0010;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    req = '0;
    repeat (DP + 2) tick();

    // Withdrawal of requester 3 while stalled.
    id3_seen = 0;
    dout_rdy = 1'b0;
    req = 4'b0001;
    tick();
    req = '0;
    repeat (DP) tick();
    req = 4'b1000;
    repeat (2) tick();
    req = '0;
    dout_rdy = 1'b1;
    repeat (DP + 2) tick();
    check_eq("withdraw_id3", 64'(id3_seen), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (req[i] && (last_gnt[i] || $urandom_range(15) == 0)) req[i] = 1'b0;
        if (!req[i] && $urandom_range(1) == 1) begin
          req[i] = 1'b1;
          din[i*DW +: DW] = $urandom;
        end
      end
      dout_rdy = ($urandom_range(3) != 0);
      flush    = ($urandom_range(63) == 0);
      rst      = ($urandom_range(255) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    req = '0;
    dout_rdy = 1'b1;
    repeat (DP + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_pipe_arb.md
# sync_pipe_arb

Arbitrated scheduler for the shared DP-stage reset-to-zero register delay pipeline. Collects single-beat requests from NR requesters, grants at most one per cycle, and pushes the granted word plus its requester ID through the DP-deep pipeline. Presents the delayed word at the output with a valid/ready handshake, stalling the whole pipeline under backpressure. Sits between multiple tick/event sources and the single shared delay/synchronizer resource.

## Interface
- NR, 4, number of requesters (≥2)
- DP, 2, pipeline depth in stages (≥1)
- DW, 32, data width per requester
- IW, 2, requester ID width; 2^IW ≥ NR required
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  NR  per-requester request; held with din until granted
- din  input  NR*DW  packed request data; requester i at bits [i*DW +: DW]
- gnt  output  NR  one-hot grant, combinational from req/state; acceptance = req[i]&gnt[i] at a rising edge
- flush  input  1  synchronous pipeline clear
- dout_rdy  input  1  downstream ready
- dout_vld  output  1  output stage holds valid word
- dout_id  output  IW  requester index of output word
- dout  output  DW  output word
- busy  output  1  OR of all stage valid bits

## Operation
- Pipeline: DP stages, each {vld, id[IW], data[DW]}; output ports driven directly from stage DP-1.
- Advance enable: adv = !dout_vld | dout_rdy. When adv=0 all stages hold, gnt=0.
- When adv=1: stage 0 loads {1, winner id, din[winner]} if a grant issued, else {0, 0, 0} (bubble data zeroed); stage k loads stage k-1.
- Arbitration (see Configuration) over req; at most one gnt bit high; gnt=0 when req=0, adv=0, flush=1, or rst=1.
- flush=1: all stage vld, id, data cleared to 0 at next edge; no acceptance that cycle; arbiter pointer unchanged. flush overrides dout_rdy.
- rst=1: all stages zero, arbiter pointer 0; dominates flush.
- Requester protocol: req/din stable until gnt seen; dropping req before gnt is legal (request withdrawn, nothing enqueued).

## Timing
- Reset values: gnt=0, dout_vld=0, dout_id=0, dout=0, busy=0.
- Latency: word accepted at edge E appears on dout with dout_vld=1 in the cycle after edge E+DP-1 (DP=2: after 2nd edge), absent stalls.
- Each stall cycle (dout_vld=1, dout_rdy=0) adds one cycle to every in-flight word; no word dropped or duplicated.
- Throughput: one word per cycle when dout_rdy held high.
- Output word retired at edge where dout_vld&dout_rdy; simultaneous retire and accept allowed.
- Ordering: output order equals acceptance order.

## Configuration
- SYNC_PIPE_ARB_RR_EN defined: round-robin. Pointer p (reset 0); winner = first requesting index scanning p, p+1, … mod NR; after acceptance by i, p ← (i+1) mod NR; p unchanged on cycles without acceptance.
- Undefined: fixed priority, lowest requesting index wins; no pointer state.

## Test plan
- Reset: rst=1 two cycles with req=4'b1111 -> gnt=0, dout_vld=0, dout=0, busy=0; release rst -> requester 0 granted first in both configurations.
- Single request, DP=2: req=4'b0100, din[2]=32'hA5A5_0001, dout_rdy=1 -> gnt=4'b0100 one cycle; dout_vld=1, dout_id=2, dout=32'hA5A5_0001 exactly after 2nd edge.
- Contention, req=4'b1111 held 8 cycles: RR_EN -> grant order 0,1,2,3,0,1,2,3; without -> requester 0 granted every cycle, dout_id=0 stream.
- Backpressure: stream 4 words, dout_rdy=0 for 3 cycles mid-stream -> dout stable, gnt=0 while stalled, all 4 words delivered in order, no duplicates.
- Flush with 2 words in flight and req=4'b0010 -> next cycle busy=0, dout_vld=0, no grant in flush cycle; requester 1 granted the cycle after.
- Withdrawal: req[3] raised while stalled then dropped before adv -> no word with dout_id=3 ever emitted.
